// File: rtl/prog_loader_pkg.sv
// Shared types and constants for the UART program loader.
package prog_loader_pkg;

    // UART framing: 8 data bits, 1 stop bit, no parity.
    localparam int DATA_BITS        = 8;
    localparam int STOP_BITS        = 1;
    // 50 MHz clock, 115200 baud.
    localparam int DEF_CLKS_PER_BIT = 434;

    // Loader FSM: header, three bytes per word, write, checksum, final states.
    typedef enum logic [2:0] {
        ST_HDR  = 3'd0,
        ST_B0   = 3'd1,
        ST_B1   = 3'd2,
        ST_B2   = 3'd3,
        ST_WR   = 3'd4,
        ST_CHK  = 3'd5,
        ST_DONE = 3'd6,
        ST_ERR  = 3'd7
    } state_t;

    // Receiver FSM.
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, glitch-rejecting
// start detection and stop-bit framing check.
module uart_rx
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       frame_err_pulse
);

    localparam int                CNT_W     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [1:0]           r_sync;
    logic                 r_rx_prev;
    rx_state_t            r_state;
    rx_state_t            w_state_next;
    logic [CNT_W-1:0]     r_cnt;
    logic [2:0]           r_bit_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_stop_bad;

    logic w_rx;
    logic w_fall;
    logic w_cnt_last;
    logic w_last_data;
    logic w_last_stop;
    logic w_stop_sample;
    logic w_stop_bad_all;

    assign w_rx        = r_sync[1];
    assign w_fall      = r_rx_prev & ~w_rx;
    // The start bit is re-checked after half a bit; every later sample is a full bit apart.
    assign w_cnt_last  = (r_state == RX_START) ? (r_cnt == HALF_LAST) : (r_cnt == FULL_LAST);
    assign w_last_data = (r_bit_idx == 3'(DATA_BITS - 1));
    assign w_last_stop = (r_bit_idx == 3'(STOP_BITS - 1));

    // Synchronize the asynchronous line and keep the previous value for edge detection.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync    <= 2'b11;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync    <= {r_sync[0], rx};
            r_rx_prev <= w_rx;
        end
    end

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= RX_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Receiver next-state logic.
    // NOTE: the default assignment first means every path drives the signal, so no latch is inferred.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            RX_IDLE: begin
                if (w_fall) w_state_next = RX_START;
            end
            RX_START: begin
                // A line that is high again at mid-start was a glitch.
                if (w_cnt_last) w_state_next = w_rx ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                if (w_cnt_last && w_last_data) w_state_next = RX_STOP;
            end
            RX_STOP: begin
                if (w_cnt_last && w_last_stop) w_state_next = RX_IDLE;
            end
            default: w_state_next = RX_IDLE;
        endcase
    end

    // Bit timer, bit index, data shift register and stop-bit accumulator.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_bit_idx  <= '0;
            r_shift    <= '0;
            r_stop_bad <= 1'b0;
        end else begin
            if (r_state == RX_IDLE || w_cnt_last) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end

            case (r_state)
                RX_IDLE: begin
                    r_bit_idx  <= '0;
                    r_stop_bad <= 1'b0;
                end
                RX_START: begin
                    if (w_cnt_last) r_bit_idx <= '0;
                end
                RX_DATA: begin
                    if (w_cnt_last) begin
                        // LSB arrives first, so shift in from the top.
                        r_shift   <= {w_rx, r_shift[DATA_BITS-1:1]};
                        r_bit_idx <= w_last_data ? 3'd0 : r_bit_idx + 3'd1;
                    end
                end
                RX_STOP: begin
                    if (w_cnt_last) begin
                        r_stop_bad <= r_stop_bad | ~w_rx;
                        r_bit_idx  <= r_bit_idx + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Byte and framing-error strobes, valid in the cycle of the last stop-bit sample.
    always_comb begin
        w_stop_sample   = (r_state == RX_STOP) && w_cnt_last && w_last_stop;
        w_stop_bad_all  = r_stop_bad | ~w_rx;
        byte_valid      = w_stop_sample & ~w_stop_bad_all;
        frame_err_pulse = w_stop_sample &  w_stop_bad_all;
        byte_out        = r_shift;
    end

endmodule

// File: rtl/prog_loader.sv
// Boot loader: receives a UART program frame, writes 20-bit words into BRAM
// port A, verifies the XOR checksum and releases the core with run.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic              wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic              busy,
    output logic              run,
    output logic              frame_err,
    output logic              chk_err,
    output logic [ADDR_W:0]   words
);

    // Bits of instruction taken from the low part of byte0.
    localparam int HI_W = DATA_W - 16;

    logic [7:0]        w_byte;
    logic              w_byte_valid;
    logic              w_frame_err_pulse;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W:0]   r_n;
    logic [ADDR_W:0]   r_words;
    logic [7:0]        r_xor;
    logic [HI_W-1:0]   r_b0;
    logic [7:0]        r_b1;
    logic [ADDR_W-1:0] r_addra;
    logic [DATA_W-1:0] r_dina;
    logic              r_frame_err;
    logic              r_chk_err;

    logic [ADDR_W:0]   w_words_inc;
    logic [ADDR_W:0]   w_hdr_n;
    logic              w_live;
    logic              w_abort;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx (
        .clk            (clk),
        .rst            (rst),
        .rx             (rx),
        .byte_out       (w_byte),
        .byte_valid     (w_byte_valid),
        .frame_err_pulse(w_frame_err_pulse)
    );

    assign w_words_inc = r_words + 1'b1;
    // A header of zero encodes a full memory.
    assign w_hdr_n     = (w_byte == 8'd0) ? (ADDR_W + 1)'(1 << ADDR_W) : (ADDR_W + 1)'(w_byte);
    // Framing errors matter only until the loader reaches a final state.
    assign w_live      = (r_state != ST_DONE) && (r_state != ST_ERR);
    assign w_abort     = w_frame_err_pulse && w_live && (r_state != ST_HDR);

    // Loader state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_HDR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Loader next-state logic; a framing error mid-frame aborts to ERR.
    always_comb begin
        w_state_next = r_state;
        if (w_abort) begin
            w_state_next = ST_ERR;
        end else begin
            case (r_state)
                ST_HDR:  if (w_byte_valid) w_state_next = ST_B0;
                ST_B0:   if (w_byte_valid) w_state_next = ST_B1;
                ST_B1:   if (w_byte_valid) w_state_next = ST_B2;
                ST_B2:   if (w_byte_valid) w_state_next = ST_WR;
                ST_WR:   w_state_next = (w_words_inc == r_n) ? ST_CHK : ST_B0;
                ST_CHK: begin
                    if (w_byte_valid) w_state_next = (w_byte == r_xor) ? ST_DONE : ST_ERR;
                end
                ST_DONE: w_state_next = ST_DONE;
                ST_ERR:  w_state_next = ST_ERR;
                default: w_state_next = ST_HDR;
            endcase
        end
    end

    // Loader outputs decoded from state and the BRAM-side registers.
    always_comb begin
        wea       = (r_state == ST_WR);
        busy      = (r_state == ST_B0) || (r_state == ST_B1) || (r_state == ST_B2) ||
                    (r_state == ST_WR) || (r_state == ST_CHK);
        run       = (r_state == ST_DONE);
        addra     = r_addra;
        dina      = r_dina;
        frame_err = r_frame_err;
        chk_err   = r_chk_err;
        words     = r_words;
    end

    // Word assembly, running XOR, word counter and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_n         <= '0;
            r_words     <= '0;
            r_xor       <= '0;
            r_b0        <= '0;
            r_b1        <= '0;
            r_addra     <= '0;
            r_dina      <= '0;
            r_frame_err <= 1'b0;
            r_chk_err   <= 1'b0;
        end else begin
            if (w_frame_err_pulse && w_live) r_frame_err <= 1'b1;

            case (r_state)
                ST_HDR: begin
                    if (w_byte_valid) begin
                        r_n   <= w_hdr_n;
                        r_xor <= w_byte;
                    end
                end
                ST_B0: begin
                    if (w_byte_valid) begin
                        // Upper bits of byte0 are dropped but still feed the checksum.
                        r_b0  <= w_byte[HI_W-1:0];
                        r_xor <= r_xor ^ w_byte;
                    end
                end
                ST_B1: begin
                    if (w_byte_valid) begin
                        r_b1  <= w_byte;
                        r_xor <= r_xor ^ w_byte;
                    end
                end
                ST_B2: begin
                    if (w_byte_valid) begin
                        // Address and data are loaded here and held until the next word.
                        r_addra <= r_words[ADDR_W-1:0];
                        r_dina  <= {r_b0, r_b1, w_byte};
                        r_xor   <= r_xor ^ w_byte;
                    end
                end
                ST_WR: begin
                    r_words <= w_words_inc;
                end
                ST_CHK: begin
                    if (w_byte_valid && (w_byte != r_xor)) r_chk_err <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Scoreboard bench for prog_loader: stimulus pushes expected BRAM writes,
// a monitor pops and compares on every wea pulse.
module tb_prog_loader;

    localparam int CPB    = 4;
    localparam int ADDR_W = 6;
    localparam int DATA_W = 20;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    logic              clk = 1'b0;
    logic              rst;
    logic              rx;
    logic              wea;
    logic [ADDR_W-1:0] addra;
    logic [DATA_W-1:0] dina;
    logic              busy;
    logic              run;
    logic              frame_err;
    logic              chk_err;
    logic [ADDR_W:0]   words;

    int   n_checks = 0;
    int   n_errors = 0;
    wr_t  exp_q[$];
    logic [7:0] tx_xor;
    int   next_addr;

    always #5 clk = ~clk;

    prog_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .wea      (wea),
        .addra    (addra),
        .dina     (dina),
        .busy     (busy),
        .run      (run),
        .frame_err(frame_err),
        .chk_err  (chk_err),
        .words    (words)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One 8N1 byte followed by two idle bit times; stop_ok=0 drives a bad stop bit.
    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok;
        repeat (CPB) @(negedge clk);
        rx = 1'b1;
        repeat (2 * CPB) @(negedge clk);
    endtask

    task automatic start_frame(input logic [7:0] n);
        tx_xor    = n;
        next_addr = 0;
        send_byte(n, 1'b1);
    endtask

    task automatic send_word(input logic [DATA_W-1:0] w, input logic [3:0] b0_hi);
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        wr_t        e;
        b0     = {b0_hi, w[19:16]};
        b1     = w[15:8];
        b2     = w[7:0];
        e.addr = ADDR_W'(next_addr);
        e.data = w;
        exp_q.push_back(e);
        next_addr++;
        tx_xor = tx_xor ^ b0 ^ b1 ^ b2;
        send_byte(b0, 1'b1);
        send_byte(b1, 1'b1);
        send_byte(b2, 1'b1);
    endtask

    task automatic end_frame(input logic good);
        send_byte(good ? tx_xor : (tx_xor ^ 8'h01), 1'b1);
    endtask

    task automatic do_reset();
        rx  = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_reset_values();
        check("rst_wea",       wea,       0);
        check("rst_addra",     addra,     0);
        check("rst_dina",      dina,      0);
        check("rst_busy",      busy,      0);
        check("rst_run",       run,       0);
        check("rst_frame_err", frame_err, 0);
        check("rst_chk_err",   chk_err,   0);
        check("rst_words",     words,     0);
    endtask

    // Monitor: every wea pulse must match the oldest expected write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (wea === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_unexpected_wea: write at addr 0x%0h data 0x%0h, expected no write",
                             addra, dina);
                end else begin
                    e = exp_q.pop_front();
                    check("wea_addr", addra, e.addr);
                    check("wea_data", dina,  e.data);
                end
            end
        end
    end

    // Watchdog so the bench always ends.
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rx  = 1'b1;
        rst = 1'b1;
        do_reset();
        check_reset_values();

        // Glitch: a 1-cycle low pulse must not start a byte.
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        repeat (12 * CPB) @(negedge clk);
        check("glitch_busy",  busy,      0);
        check("glitch_words", words,     0);
        check("glitch_ferr",  frame_err, 0);

        // Single word: 01 0A BC DE + checksum.
        start_frame(8'h01);
        check("single_busy_hdr", busy, 1);
        send_word(20'hABCDE, 4'h0);
        end_frame(1'b1);
        check("single_run",   run,     1);
        check("single_busy",  busy,    0);
        check("single_words", words,   1);
        check("single_chk",   chk_err, 0);
        check("single_addra", addra,   0);
        check("single_dina",  dina,    20'hABCDE);
        // Bytes after DONE are ignored.
        send_byte(8'h01, 1'b1);
        send_byte(8'h0A, 1'b1);
        send_byte(8'hBC, 1'b1);
        send_byte(8'hDE, 1'b1);
        check("done_run_hold",   run,   1);
        check("done_words_hold", words, 1);

        // Bad checksum.
        do_reset();
        start_frame(8'h01);
        send_word(20'hABCDE, 4'h0);
        end_frame(1'b0);
        check("badchk_chk_err", chk_err, 1);
        check("badchk_run",     run,     0);
        check("badchk_busy",    busy,    0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h0A, 1'b1);
        send_byte(8'hBC, 1'b1);
        send_byte(8'hDE, 1'b1);
        check("badchk_words_hold", words, 1);
        check("badchk_run_hold",   run,   0);

        // Full memory: header 0 means 64 words.
        do_reset();
        start_frame(8'h00);
        for (int i = 0; i < 64; i++) begin
            logic [7:0] bi;
            bi = 8'(i);
            send_word({4'h0, bi, ~bi}, 4'h0);
        end
        end_frame(1'b1);
        check("full_run",   run,     1);
        check("full_words", words,   64);
        check("full_addra", addra,   63);
        check("full_dina",  dina,    {4'h0, 8'h3F, 8'hC0});
        check("full_chk",   chk_err, 0);

        // Frame error on byte1 of a word.
        do_reset();
        start_frame(8'h02);
        send_byte(8'h03, 1'b1);
        send_byte(8'h45, 1'b0);
        check("ferr_b1_flag",  frame_err, 1);
        check("ferr_b1_busy",  busy,      0);
        check("ferr_b1_run",   run,       0);
        check("ferr_b1_words", words,     0);
        send_byte(8'h67, 1'b1);
        send_byte(8'h12, 1'b1);
        send_byte(8'h34, 1'b1);
        check("ferr_b1_run_hold", run, 0);

        // Frame error on the header stays in HDR; a good frame then loads.
        do_reset();
        send_byte(8'h01, 1'b0);
        check("ferr_hdr_flag", frame_err, 1);
        check("ferr_hdr_busy", busy,      0);
        start_frame(8'h01);
        check("ferr_hdr_accept", busy, 1);
        send_word(20'h12345, 4'h0);
        end_frame(1'b1);
        check("ferr_hdr_run",    run,       1);
        check("ferr_hdr_sticky", frame_err, 1);
        check("ferr_hdr_chk",    chk_err,   0);

        // Reset after two of four words, then resend the whole frame.
        do_reset();
        start_frame(8'h04);
        send_word(20'h11111, 4'hF);
        send_word(20'h22F0F, 4'h3);
        check("mid_words", words, 2);
        check("mid_busy",  busy,  1);
        do_reset();
        check_reset_values();
        start_frame(8'h04);
        send_word(20'h11111, 4'hF);
        send_word(20'h22F0F, 4'h3);
        send_word(20'hFEDCB, 4'hA);
        send_word(20'h00001, 4'h0);
        end_frame(1'b1);
        check("reload_run",   run,   1);
        check("reload_words", words, 4);
        check("reload_addra", addra, 3);

        check("sb_drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
